// File: rtl/i2s_pkg.sv
// Shared constants, types and helpers for the I2S DAC transmitter.
// The DEF_* values describe the default build; modules take their own
// parameters and derive widths with the helper functions below.
package i2s_pkg;

  localparam int DEF_CLK_DIV  = 8;
  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_SLOT_W   = 32;

  // Default-build frame geometry: two channel slots per frame.
  localparam int FRAME_BITS = 2 * DEF_SLOT_W;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  typedef logic signed [DEF_SAMPLE_W-1:0] sample_t;

  // Number of BCLK periods in one stereo frame.
  function automatic int frame_bits(input int slot_w);
    return 2 * slot_w;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flipflop.sv
// Generic enabled register with synchronous active-high reset.
module flipflop #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture d whenever en is asserted; clear on reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides clk down to BCLK and flags the clk cycle in
// which BCLK goes 1->0, which is when the serial side is allowed to update.
module i2s_bclk_gen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic srst,
  output logic bclk,
  output logic fall_tick
);

  localparam int              DIV_W    = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic             div_wrap;

  assign div_wrap = (div_cnt_reg == DIV_LAST);

  // The edge that toggles a high BCLK low is the falling edge of BCLK.
  assign fall_tick = div_wrap && bclk;

  // Half-period counter; BCLK flips each time it wraps.
  always_ff @(posedge clk) begin
    if (srst) begin
      div_cnt_reg <= '0;
      bclk        <= 1'b0;
    end else if (div_wrap) begin
      div_cnt_reg <= '0;
      bclk        <= ~bclk;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S transmitter feeding an external audio DAC. A mono sample from the
// effects pipeline is buffered in a one-deep pending register, promoted to
// the active register at each frame start, and sent MSB first in both the
// left and right 32-bit slots. All serial outputs move only with BCLK falls,
// so the DAC, sampling on BCLK rise, always sees settled data.
module i2s_dac_tx
  import i2s_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int SLOT_W   = DEF_SLOT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                sample_req,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                underrun,
  output logic                overrun
);

  localparam int               FRAME_LEN = frame_bits(SLOT_W);
  localparam int               POS_W     = cnt_width(FRAME_LEN);
  localparam logic [POS_W-1:0] LAST_POS  = POS_W'(FRAME_LEN - 1);
  localparam logic [POS_W-1:0] SLOT_POS  = POS_W'(SLOT_W);

  logic                fall_tick;
  logic                frame_load;
  logic [POS_W-1:0]    bit_cnt_reg;
  logic [POS_W-1:0]    bit_cnt_next;
  logic [POS_W-1:0]    lr_pos;
  logic [POS_W-1:0]    slot_idx;
  logic [SAMPLE_W-1:0] pending_q;
  logic [SAMPLE_W-1:0] active_reg;
  logic [SAMPLE_W-1:0] active_next;
  logic [SAMPLE_W-1:0] bit_hit;
  logic                pend_full_reg;
  logic                sdata_next;
  logic                lrclk_next;

  i2s_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .clk       (clk),
    .srst      (rst),
    .bclk      (bclk),
    .fall_tick (fall_tick)
  );

  // Pending slot: newest sample always wins; the active register reads the
  // old value in the same cycle, which is what makes a load coincident
  // with valid consume the previous sample.
  flipflop #(
    .W (SAMPLE_W)
  ) u_pending (
    .clk  (clk),
    .srst (rst),
    .en   (valid),
    .d    (sample_in),
    .q    (pending_q)
  );

  // A frame boundary is the fall tick that wraps the bit position to 0.
  assign frame_load   = fall_tick && (bit_cnt_reg == LAST_POS);
  assign bit_cnt_next = frame_load ? '0 : bit_cnt_reg + 1'b1;
  assign active_next  = (frame_load && pend_full_reg) ? pending_q : active_reg;

  // Word select leads the data by one BCLK, so it is taken from the
  // position after the one being driven.
  assign lr_pos     = (bit_cnt_next == LAST_POS) ? '0 : bit_cnt_next + 1'b1;
  assign lrclk_next = (lr_pos >= SLOT_POS);

  // Bit index within the current channel slot.
  assign slot_idx = (bit_cnt_next >= SLOT_POS) ? bit_cnt_next - SLOT_POS : bit_cnt_next;

  // One-hot bit select, MSB first; positions past the sample width are zero.
  for (genvar gi = 0; gi < SAMPLE_W; gi++) begin : g_bit_sel
    assign bit_hit[gi] = (slot_idx == POS_W'(gi)) && active_next[SAMPLE_W-1-gi];
  end

  assign sdata_next = |bit_hit;

  // Frame sequencing, input bookkeeping and registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg   <= '0;
      active_reg    <= '0;
      pend_full_reg <= 1'b0;
      sample_req    <= 1'b0;
      underrun      <= 1'b0;
      overrun       <= 1'b0;
      sdata         <= 1'b0;
      lrclk         <= 1'b0;
    end else begin
      sample_req <= frame_load;
      underrun   <= frame_load && !pend_full_reg;
      overrun    <= valid && pend_full_reg && !frame_load;

      if (valid) begin
        pend_full_reg <= 1'b1;
      end else if (frame_load) begin
        pend_full_reg <= 1'b0;
      end

      if (fall_tick) begin
        bit_cnt_reg <= bit_cnt_next;
        active_reg  <= active_next;
        sdata       <= sdata_next;
        lrclk       <= lrclk_next;
      end
    end
  end

endmodule
